// File: rtl/arbiter_mux.sv
// rtl/arbiter_mux.sv - packet mux that drives a round-robin arbiter and steers the granted stream
//
// Purpose: turns NUM_PORTS valid/ready/last input streams into the arbiter request
// vector, follows the arbiter's registered grant, and forwards the granted port's
// packet onto one registered output stream without interleaving packets.
//
// Optional feature macro: ARBITER_MUX_BURST_LIMIT_EN
//   defined   - a grant ends after MAX_BEATS accepted beats even without in_last;
//               the packet resumes on the port's next grant.
//   undefined - only an accepted in_last ends a grant; MAX_BEATS is not used.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid      per-port beat valid
//   in_ready      per-port beat accept (only the selected port can be ready)
//   in_last       per-port final beat of packet
//   in_data       port i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   arb_request   request vector to the arbiter, bit i = port i
//   arb_grant     registered one-hot (or zero) grant from the arbiter
//   arb_active    arbiter has a grant outstanding
//   out_valid     output beat valid
//   out_ready     downstream accept
//   out_last      output final beat
//   out_data      output payload
//   out_port      source port of the current output beat
module arbiter_mux #(
    parameter int NUM_PORTS  = 6,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16,
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [NUM_PORTS-1:0]            in_ready,
    input  logic [NUM_PORTS-1:0]            in_last,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic [0:NUM_PORTS-1]            arb_request,
    input  logic [0:NUM_PORTS-1]            arb_grant,
    input  logic                            arb_active,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [PORT_W-1:0]               out_port
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_RELEASE
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [PORT_W-1:0]       sel;
    logic [PORT_W-1:0]       grant_idx;
    logic                    sel_valid;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    sel_ready;
    logic                    accept;
    logic                    burst_done;

    // Index of the granted port; the grant is one-hot so the last hit wins.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (arb_grant[i]) begin
                grant_idx = PORT_W'(i);
            end
        end
    end

    // Selected input stream.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (sel == PORT_W'(i)) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign sel_ready = ~out_valid | out_ready;
    assign accept    = (state == S_XFER) & sel_valid & sel_ready;

`ifdef ARBITER_MUX_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic [CNT_W-1:0] beat_cnt;

    // Cleared while idle, so every grant starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (state == S_IDLE) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    assign burst_done = (beat_cnt == CNT_W'(MAX_BEATS - 1));
`else
    logic unused_max_beats;

    assign unused_max_beats = ^MAX_BEATS;
    assign burst_done       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (arb_active) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (accept && (sel_last || burst_done)) begin
                    state_d = S_RELEASE;
                end
            end
            // One cycle with the request dropped so the arbiter moves its token,
            // while its still-registered old grant is ignored.
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= '0;
        end else if (state == S_IDLE && arb_active) begin
            sel <= grant_idx;
        end
    end

    // The selected port keeps requesting for the whole packet even if its valid
    // drops, and is masked for the single release cycle.
    always_comb begin
        arb_request = '0;
        in_ready    = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                arb_request[i] = ((state == S_XFER) && (sel == PORT_W'(i))) ||
                                 (in_valid[i] && !((state == S_RELEASE) && (sel == PORT_W'(i))));
                in_ready[i]    = (state == S_XFER) && (sel == PORT_W'(i)) && sel_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_last  <= sel_last;
            out_data  <= sel_data;
            out_port  <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arbiter_mux.sv
// tb/tb_arbiter_mux.sv - self-checking bench for arbiter_mux with a round-robin arbiter model
module tb_arbiter_mux;

    localparam int N  = 6;
    localparam int DW = 32;
    localparam int PW = 3;
`ifdef ARBITER_MUX_BURST_LIMIT_EN
    localparam int MB = 4;
`else
    localparam int MB = 16;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          first;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N-1:0]      in_last;
    logic [N*DW-1:0]   in_data;
    logic [0:N-1]      arb_request;
    logic [0:N-1]      arb_grant;
    logic              arb_active;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [DW-1:0]     out_data;
    logic [PW-1:0]     out_port;

    always #5 clk = ~clk;

    arbiter_mux #(
        .NUM_PORTS  (N),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .in_data     (in_data),
        .arb_request (arb_request),
        .arb_grant   (arb_grant),
        .arb_active  (arb_active),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .out_data    (out_data),
        .out_port    (out_port)
    );

    // Round-robin arbiter: holder keeps the grant while requesting, otherwise
    // the first requester after the last granted port wins; registered output.
    int tok;
    always @(posedge clk) begin : arb_model
        int           cur;
        int           nt;
        logic [0:N-1] ng;
        if (rst) begin
            arb_grant <= '0;
            tok       <= N - 1;
        end else begin
            ng  = '0;
            nt  = tok;
            cur = -1;
            for (int i = 0; i < N; i++) if (arb_grant[i]) cur = i;
            if (cur >= 0 && arb_request[cur]) begin
                ng = arb_grant;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (ng == '0 && arb_request[(tok + k) % N]) begin
                        ng[(tok + k) % N] = 1'b1;
                        nt = (tok + k) % N;
                    end
                end
            end
            arb_grant <= ng;
            tok       <= nt;
        end
    end
    assign arb_active = |arb_grant;

    int checks   = 0;
    int failures = 0;

    beat_t drv_q [N][$];
    beat_t exp_q [N][$];
    logic [N-1:0] gate;
    bit    rand_gate;
    int    ready_mode;
    int    cyc;
    int    fire_port[$];
    int    fire_cyc[$];
    int    acc_last_cyc[$];
    logic [0:N-1] req_hist[int];
    int    pkt_beats[N];
    int    prev_port;
    bit    stall_prev;
    logic [DW-1:0] sv_data;
    logic  sv_last;
    logic [PW-1:0] sv_port;
    int    stall_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int p, input int nbeats, input logic [DW-1:0] base);
        beat_t x;
        for (int b = 0; b < nbeats; b++) begin
            x.data  = base + DW'(b);
            x.last  = (b == nbeats - 1);
            x.first = (b == 0);
            drv_q[p].push_back(x);
            exp_q[p].push_back(x);
        end
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) begin
            if (drv_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: drive at edge+1, sample and score at edge+2.
    task automatic step();
        beat_t e;
        int    p;
        bit    ok;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (drv_q[i].size() > 0 && gate[i] &&
                (!rand_gate || drv_q[i][0].first || $urandom_range(0, 3) != 0)) begin
                in_valid[i]          = 1'b1;
                in_last[i]           = drv_q[i][0].last;
                in_data[i*DW +: DW]  = drv_q[i][0].data;
            end else begin
                in_valid[i]          = 1'b0;
                in_last[i]           = 1'b0;
                in_data[i*DW +: DW]  = '0;
            end
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = cyc[0];
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        req_hist[cyc] = arb_request;
        chk("in_ready_at_most_one", ($countones(in_ready) <= 1), 1);
        if (stall_prev) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, sv_data);
            chk("stall_last", out_last, sv_last);
            chk("stall_port", out_port, sv_port);
        end
        stall_prev = out_valid && !out_ready;
        sv_data    = out_data;
        sv_last    = out_last;
        sv_port    = out_port;
        if (stall_prev) stall_cnt++;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                if (drv_q[i][0].last) acc_last_cyc.push_back(cyc);
                void'(drv_q[i].pop_front());
            end
        end
        if (out_valid && out_ready) begin
            p = int'(out_port);
            if (p < N && exp_q[p].size() > 0) begin
                e = exp_q[p].pop_front();
                chk("sb_data", out_data, e.data);
                chk("sb_last", out_last, e.last);
            end else begin
                chk("sb_unexpected_port", p, N);
            end
            if (p < N) begin
                ok = (prev_port < 0) || (prev_port == p) || (pkt_beats[prev_port] == 0);
`ifdef ARBITER_MUX_BURST_LIMIT_EN
                if (!ok && (pkt_beats[prev_port] % MB) == 0) ok = 1'b1;
`endif
                chk("no_interleave", ok, 1);
                pkt_beats[p] = out_last ? 0 : pkt_beats[p] + 1;
            end
            prev_port = p;
            fire_port.push_back(p);
            fire_cyc.push_back(cyc);
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (!all_done() && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, all_done(), 1);
        repeat (4) step();
    endtask

    task automatic clear_logs();
        fire_port.delete();
        fire_cyc.delete();
        acc_last_cyc.delete();
        stall_cnt = 0;
    endtask

    task automatic chk_seq(input string tag, input int exp_seq[$]);
        chk({tag, "_count"}, fire_port.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size() && i < fire_port.size(); i++) begin
            chk({tag, "_port"}, fire_port[i], exp_seq[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s[$];
        int n;
        logic [DW-1:0] base;
        int p;

        rst        = 1'b1;
        in_valid   = '1;
        in_last    = '0;
        in_data    = '0;
        out_ready  = 1'b1;
        gate       = '1;
        rand_gate  = 1'b0;
        ready_mode = 0;
        cyc        = 0;
        prev_port  = -1;
        stall_prev = 1'b0;
        stall_cnt  = 0;
        for (int i = 0; i < N; i++) pkt_beats[i] = 0;

        // 1. reset with every port valid
        repeat (2) begin
            @(posedge clk);
            #2;
            chk("rst_request", arb_request, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
        end
        rst      = 1'b0;
        in_valid = '0;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_port", out_port, 0);
        chk("rst_out_last", out_last, 0);

        // 2. port0 4-beat packet, then a 1-beat packet keeps port0 valid
        clear_logs();
        send(0, 4, 32'hA0);
        send(0, 1, 32'hB0);
        drain(200, "t2");
        chk("t2_fires", fire_port.size(), 5);
        if (fire_port.size() == 5) begin
            chk("t2_port", fire_port[0], 0);
            for (int i = 1; i < 4; i++) chk("t2_back_to_back", fire_cyc[i] - fire_cyc[i-1], 1);
            chk("t2_regrant_gap", fire_cyc[4] - fire_cyc[3], 4);
        end
        chk("t2_last_accepts", acc_last_cyc.size(), 2);
        if (acc_last_cyc.size() == 2) begin
            chk("t2_req0_release", req_hist[acc_last_cyc[0] + 1][0], 0);
            chk("t2_req0_back", req_hist[acc_last_cyc[0] + 2][0], 1);
        end

        // 3. ports 1 and 3 together
        clear_logs();
        send(1, 2, 32'h100);
        send(3, 2, 32'h300);
        drain(200, "t3");
        s = '{1, 1, 3, 3};
        chk_seq("t3", s);
        if (fire_cyc.size() == 4) chk("t3_gap_ge2", (fire_cyc[2] - fire_cyc[1]) >= 2, 1);

        // 4. out_ready toggling during a 5-beat packet
        clear_logs();
        ready_mode = 1;
        send(5, 5, 32'h500);
        drain(200, "t4");
        s = '{5, 5, 5, 5, 5};
        chk_seq("t4", s);
        chk("t4_stalls_seen", stall_cnt > 0, 1);
        ready_mode = 0;

        // 5. port2 drops valid mid-packet while port4 waits
        clear_logs();
        send(2, 4, 32'h200);
        send(4, 2, 32'h400);
        n = 0;
        while (drv_q[2].size() > 2 && n < 50) begin
            step();
            n++;
        end
        chk("t5_reach_mid", drv_q[2].size(), 2);
        gate[2] = 1'b0;
        repeat (3) begin
            step();
            chk("t5_req2_held", arb_request[2], 1);
        end
        gate[2] = 1'b1;
        drain(200, "t5");
        s = '{2, 2, 2, 2, 4, 4};
        chk_seq("t5", s);

        // 6. 10-beat packet on port5 with port0 competing
        clear_logs();
        send(5, 10, 32'h5000);
        send(0, 2, 32'h0100);
        send(0, 2, 32'h0200);
        drain(300, "t6");
`ifdef ARBITER_MUX_BURST_LIMIT_EN
        s = '{5, 5, 5, 5, 0, 0, 5, 5, 5, 5, 0, 0, 5, 5};
`else
        s = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 0, 0, 0, 0};
`endif
        chk_seq("t6", s);

        // 7. randomized packets, valid gaps and backpressure
        clear_logs();
        ready_mode = 2;
        rand_gate  = 1'b1;
        for (int k = 0; k < 40; k++) begin
            p    = int'($urandom_range(0, N - 1));
            base = {8'(p), 8'(k), 16'h0};
            send(p, int'($urandom_range(1, 6)), base);
        end
        drain(6000, "t7");
        ready_mode = 0;
        rand_gate  = 1'b0;

        // 8. reset mid-packet
        clear_logs();
        send(1, 4, 32'h700);
        n = 0;
        while (fire_port.size() < 2 && n < 50) begin
            step();
            n++;
        end
        chk("t8_mid_packet", fire_port.size() >= 2, 1);
        rst = 1'b1;
        repeat (2) begin
            step();
            chk("t8_rst_out_valid", out_valid, 0);
            chk("t8_rst_request", arb_request, 0);
            chk("t8_rst_in_ready", in_ready, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            exp_q[i].delete();
            pkt_beats[i] = 0;
        end
        prev_port  = -1;
        stall_prev = 1'b0;
        clear_logs();
        repeat (4) begin
            step();
            chk("t8_no_resume", out_valid, 0);
        end
        send(1, 2, 32'h710);
        drain(200, "t8");
        s = '{1, 1};
        chk_seq("t8", s);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
